// File: rtl/imem_loader.sv
// imem_loader
//   Receives a little-endian program image over a byte stream and writes it,
//   one 32-bit word per strobe, into the instruction memory write port.
//   The CPU is held in reset (CpuHold) until a complete image has loaded.
//
//   Image format: 4 length bytes (N = word count), then N words of 4 bytes.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   Start         single-cycle pulse arming a load (ignored while loading)
//   ByteValid     ByteData is valid
//   ByteData      stream byte
//   ByteReady     loader accepts a byte this cycle (LEN/DATA only)
//   WriteEnable   one-cycle write strobe to instruction memory
//   WriteAddress  byte address of the word being written
//   WriteData     word being written
//   Busy          load in progress
//   Done          image loaded successfully (level)
//   Error         load aborted by bad length or timeout (level)
//   CpuHold       keeps the CPU in reset
//   WordsWritten  words written in the current load
module imem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        WriteEnable,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic        CpuHold,
  output logic [15:0] WordsWritten
);

  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);
  localparam logic [15:0] DEPTH_SAT = 16'(DEPTH_WORDS);
  localparam logic [31:0] TMO_LIM   = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  logic [31:0] asm_word;
  logic [1:0]  bidx;
  logic [31:0] nwords;
  logic [31:0] tcnt;

  logic        accept;
  logic        last_byte;
  logic        tmo_hit;
  logic [31:0] next_word;

  assign ByteReady = (state == LEN) || (state == DATA);
  assign accept    = ByteValid && ByteReady;
  assign last_byte = (bidx == 2'd3);
  // Incoming bytes shift in from the top so the first byte ends in bits 7:0.
  assign next_word = {ByteData, asm_word[31:8]};
  // Fires on the idle edge that would bring the counter to TIMEOUT_CYCLES.
  assign tmo_hit   = (TMO_LIM != 32'd0) && (tcnt == TMO_LIM - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      asm_word     <= 32'd0;
      bidx         <= 2'd0;
      nwords       <= 32'd0;
      tcnt         <= 32'd0;
      WriteEnable  <= 1'b0;
      WriteAddress <= 32'd0;
      WriteData    <= 32'd0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      CpuHold      <= 1'b1;
      WordsWritten <= 16'd0;
    end else begin
      WriteEnable <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (Start) begin
            state        <= LEN;
            Busy         <= 1'b1;
            Done         <= 1'b0;
            Error        <= 1'b0;
            CpuHold      <= 1'b1;
            WordsWritten <= 16'd0;
            tcnt         <= 32'd0;
            bidx         <= 2'd0;
          end
        end
        LEN, DATA: begin
          if (accept) begin
            tcnt     <= 32'd0;
            asm_word <= next_word;
            bidx     <= bidx + 2'd1;
            if (last_byte && (state == LEN)) begin
              nwords <= next_word;
              if (next_word == 32'd0) begin
                state   <= DONE;
                Busy    <= 1'b0;
                Done    <= 1'b1;
                CpuHold <= 1'b0;
              end else if (next_word > DEPTH_LIM) begin
                state <= ERROR;
                Busy  <= 1'b0;
                Error <= 1'b1;
              end else begin
                state <= DATA;
              end
            end else if (last_byte) begin
              // Write registers are separate from asm_word, so streaming
              // continues while this word is being strobed out.
              WriteEnable  <= 1'b1;
              WriteAddress <= BASE_ADDR + {14'd0, WordsWritten, 2'b00};
              WriteData    <= next_word;
              if (WordsWritten != DEPTH_SAT)
                WordsWritten <= WordsWritten + 16'd1;
              if ({16'd0, WordsWritten} == nwords - 32'd1) begin
                state   <= DONE;
                Busy    <= 1'b0;
                Done    <= 1'b1;
                CpuHold <= 1'b0;
              end
            end
          end else if (tmo_hit) begin
            // Any partially assembled word is dropped; bidx restarts on LEN entry.
            state <= ERROR;
            Busy  <= 1'b0;
            Error <= 1'b1;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 256;
  localparam int          TMO   = 16;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic        ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic        CpuHold;
  logic [15:0] WordsWritten;

  imem_loader #(
    .BASE_ADDR(BASE),
    .DEPTH_WORDS(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Start(Start),
    .ByteValid(ByteValid),
    .ByteData(ByteData),
    .ByteReady(ByteReady),
    .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteData(WriteData),
    .Busy(Busy),
    .Done(Done),
    .Error(Error),
    .CpuHold(CpuHold),
    .WordsWritten(WordsWritten)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] img_words[$];
  logic [7:0]  img_bytes[$];
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic        cap_done[$];

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (WriteEnable === 1'b1) begin
      cap_addr.push_back(WriteAddress);
      cap_data.push_back(WriteData);
      cap_done.push_back(Done);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic clear_capture();
    cap_addr.delete();
    cap_data.delete();
    cap_done.delete();
  endtask

  // Image bytes from the format rules: LE length, then LE words.
  task automatic build_bytes(input logic [31:0] n);
    logic [31:0] w;
    img_bytes.delete();
    for (int i = 0; i < 4; i++) img_bytes.push_back(n[8*i +: 8]);
    foreach (img_words[k]) begin
      w = img_words[k];
      for (int i = 0; i < 4; i++) img_bytes.push_back(w[8*i +: 8]);
    end
  endtask

  task automatic random_words(input int n);
    img_words.delete();
    for (int k = 0; k < n; k++) img_words.push_back($urandom);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ByteValid = 1'b1;
    ByteData  = b;
    while (ByteReady !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ByteReady !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_ready_wait: ByteReady=%b after %0d cycles, required 1", ByteReady, n);
    end
    @(negedge clk);
    ByteValid = 1'b0;
  endtask

  // Start pulse with the first byte already presented; it must not be taken.
  task automatic pulse_start(input logic [7:0] first);
    Start     = 1'b1;
    ByteValid = 1'b1;
    ByteData  = first;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic stream(input int gap_max, input int start_at, input int count);
    int g;
    for (int i = 0; i < count; i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(gap_max, 0);
        if (g > 0) begin
          ByteValid = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      if (i == start_at) begin
        ByteValid = 1'b0;
        Start     = 1'b1;
        @(negedge clk);
        Start = 1'b0;
      end
      send_byte(img_bytes[i]);
    end
  endtask

  task automatic run_image(input int gap_max, input int start_at);
    build_bytes(32'(img_words.size()));
    clear_capture();
    pulse_start(img_bytes[0]);
    stream(gap_max, start_at, img_bytes.size());
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first;
    rst_n = 1'b0; Start = 1'b0; ByteValid = 1'b0; ByteData = 8'h00;
    repeat (3) @(negedge clk);
    vectors++; if (CpuHold !== 1'b1) begin miscompares++; $display("FAIL rst_cpuhold: got %b want 1", CpuHold); end
    vectors++; if (ByteReady !== 1'b0) begin miscompares++; $display("FAIL rst_byteready: got %b want 0", ByteReady); end
    vectors++; if (WriteEnable !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", WriteEnable); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", Busy); end
    vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", Done); end
    vectors++; if (Error !== 1'b0) begin miscompares++; $display("FAIL rst_error: got %b want 0", Error); end
    vectors++; if (WordsWritten !== 16'd0) begin miscompares++; $display("FAIL rst_words: got %0d want 0", WordsWritten); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (ByteReady !== 1'b0 || CpuHold !== 1'b1) begin miscompares++; $display("FAIL idle_after_rst: ready=%b hold=%b want 0/1", ByteReady, CpuHold); end
    // Start with no bytes: error exactly TMO edges after LEN entry.
    clear_capture();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    vectors++; if (Busy !== 1'b1 || ByteReady !== 1'b1) begin miscompares++; $display("FAIL len_entry: busy=%b ready=%b want 1/1", Busy, ByteReady); end
    first = -1;
    for (int k = 1; k <= TMO + 8; k++) begin
      @(negedge clk);
      if (Error === 1'b1 && first < 0) first = k;
    end
    vectors++; if (first != TMO) begin miscompares++; $display("FAIL idle_timeout_edge: got %0d want %0d", first, TMO); end
    vectors++; if (CpuHold !== 1'b1 || Busy !== 1'b0) begin miscompares++; $display("FAIL idle_timeout_state: hold=%b busy=%b want 1/0", CpuHold, Busy); end
    vectors++; if (cap_addr.size() != 0) begin miscompares++; $display("FAIL idle_timeout_writes: got %0d want 0", cap_addr.size()); end
  endtask

  task automatic test_basic();
    img_words.delete();
    img_words.push_back(32'h0050_0013);
    img_words.push_back(32'h0021_00B3);
    run_image(0, -1);
    vectors++; if (cap_addr.size() != 2) begin miscompares++; $display("FAIL basic_nwrites: got %0d want 2", cap_addr.size()); end
    for (int k = 0; k < cap_addr.size() && k < 2; k++) begin
      vectors++; if (cap_addr[k] !== BASE + 32'(4*k)) begin miscompares++; $display("FAIL basic_addr[%0d]: got %h want %h", k, cap_addr[k], BASE + 32'(4*k)); end
      vectors++; if (cap_data[k] !== img_words[k]) begin miscompares++; $display("FAIL basic_data[%0d]: got %h want %h", k, cap_data[k], img_words[k]); end
      vectors++; if (cap_done[k] !== (k == 1)) begin miscompares++; $display("FAIL basic_done_at_we[%0d]: got %b want %b", k, cap_done[k], k == 1); end
    end
    vectors++; if (Done !== 1'b1 || CpuHold !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("FAIL basic_final: done=%b hold=%b busy=%b want 1/0/0", Done, CpuHold, Busy); end
    vectors++; if (WordsWritten !== 16'd2) begin miscompares++; $display("FAIL basic_words: got %0d want 2", WordsWritten); end
  endtask

  task automatic test_gaps();
    int n;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        img_words.delete();
        img_words.push_back(32'h0050_0013);
        img_words.push_back(32'h0021_00B3);
      end else begin
        random_words($urandom_range(8, 1));
      end
      n = img_words.size();
      run_image(6, -1);
      vectors++; if (cap_addr.size() != n) begin miscompares++; $display("FAIL gaps%0d_nwrites: got %0d want %0d", it, cap_addr.size(), n); end
      for (int k = 0; k < cap_addr.size() && k < n; k++) begin
        vectors++; if (cap_addr[k] !== BASE + 32'(4*k) || cap_data[k] !== img_words[k]) begin miscompares++; $display("FAIL gaps%0d_write[%0d]: got %h/%h want %h/%h", it, k, cap_addr[k], cap_data[k], BASE + 32'(4*k), img_words[k]); end
        vectors++; if (cap_done[k] !== (k == n-1)) begin miscompares++; $display("FAIL gaps%0d_done_at_we[%0d]: got %b want %b", it, k, cap_done[k], k == n-1); end
      end
      vectors++; if (Done !== 1'b1 || Error !== 1'b0 || CpuHold !== 1'b0 || WordsWritten !== 16'(n)) begin miscompares++; $display("FAIL gaps%0d_final: done=%b err=%b hold=%b words=%0d want 1/0/0/%0d", it, Done, Error, CpuHold, WordsWritten, n); end
    end
  endtask

  task automatic test_length_bounds();
    int first;
    img_words.delete();
    // Zero length: done on the edge that takes the 4th length byte.
    build_bytes(32'd0);
    clear_capture();
    pulse_start(img_bytes[0]);
    stream(0, -1, 4);
    vectors++; if (Done !== 1'b1 || Busy !== 1'b0 || CpuHold !== 1'b0) begin miscompares++; $display("FAIL len0_state: done=%b busy=%b hold=%b want 1/0/0", Done, Busy, CpuHold); end
    repeat (2) @(negedge clk);
    vectors++; if (cap_addr.size() != 0 || WordsWritten !== 16'd0) begin miscompares++; $display("FAIL len0_writes: got %0d/%0d want 0/0", cap_addr.size(), WordsWritten); end
    // Length 257 exceeds depth.
    build_bytes(32'd257);
    clear_capture();
    pulse_start(img_bytes[0]);
    stream(0, -1, 4);
    vectors++; if (Error !== 1'b1 || Done !== 1'b0 || CpuHold !== 1'b1) begin miscompares++; $display("FAIL len257_state: err=%b done=%b hold=%b want 1/0/1", Error, Done, CpuHold); end
    repeat (2) @(negedge clk);
    vectors++; if (cap_addr.size() != 0) begin miscompares++; $display("FAIL len257_writes: got %0d want 0", cap_addr.size()); end
    // Length equal to depth is accepted; then let it time out.
    build_bytes(32'(DEPTH));
    clear_capture();
    pulse_start(img_bytes[0]);
    stream(0, -1, 4);
    vectors++; if (Error !== 1'b0 || Busy !== 1'b1 || ByteReady !== 1'b1) begin miscompares++; $display("FAIL len256_state: err=%b busy=%b ready=%b want 0/1/1", Error, Busy, ByteReady); end
    first = -1;
    for (int k = 1; k <= TMO + 8; k++) begin
      @(negedge clk);
      if (Error === 1'b1 && first < 0) first = k;
    end
    vectors++; if (first != TMO) begin miscompares++; $display("FAIL len256_timeout_edge: got %0d want %0d", first, TMO); end
  endtask

  task automatic test_timeout_partial();
    int first;
    random_words(2);
    build_bytes(32'd2);
    clear_capture();
    pulse_start(img_bytes[0]);
    stream(2, -1, 10);
    first = -1;
    for (int k = 1; k <= TMO + 8; k++) begin
      @(negedge clk);
      if (Error === 1'b1 && first < 0) first = k;
    end
    vectors++; if (first != TMO) begin miscompares++; $display("FAIL partial_timeout_edge: got %0d want %0d", first, TMO); end
    vectors++; if (cap_addr.size() != 1) begin miscompares++; $display("FAIL partial_nwrites: got %0d want 1", cap_addr.size()); end
    if (cap_addr.size() >= 1) begin
      vectors++; if (cap_addr[0] !== BASE || cap_data[0] !== img_words[0]) begin miscompares++; $display("FAIL partial_write0: got %h/%h want %h/%h", cap_addr[0], cap_data[0], BASE, img_words[0]); end
    end
    vectors++; if (WordsWritten !== 16'd1 || CpuHold !== 1'b1 || Done !== 1'b0) begin miscompares++; $display("FAIL partial_final: words=%0d hold=%b done=%b want 1/1/0", WordsWritten, CpuHold, Done); end
  endtask

  task automatic test_reset_midload();
    int n;
    random_words(3);
    build_bytes(32'd3);
    clear_capture();
    pulse_start(img_bytes[0]);
    stream(0, -1, 8);
    vectors++; if (WriteEnable !== 1'b1) begin miscompares++; $display("FAIL mid_first_we: got %b want 1", WriteEnable); end
    #2;
    rst_n     = 1'b0;
    ByteValid = 1'b1;
    ByteData  = 8'hA5;
    #1;
    vectors++; if (CpuHold !== 1'b1 || WriteEnable !== 1'b0 || Busy !== 1'b0 || ByteReady !== 1'b0) begin miscompares++; $display("FAIL async_rst_ctrl: hold=%b we=%b busy=%b ready=%b want 1/0/0/0", CpuHold, WriteEnable, Busy, ByteReady); end
    vectors++; if (Done !== 1'b0 || Error !== 1'b0 || WordsWritten !== 16'd0 || WriteData !== 32'd0) begin miscompares++; $display("FAIL async_rst_data: done=%b err=%b words=%0d wdata=%h want 0/0/0/0", Done, Error, WordsWritten, WriteData); end
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    ByteValid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (cap_addr.size() != 1 || Busy !== 1'b0) begin miscompares++; $display("FAIL rst_no_more_writes: writes=%0d busy=%b want 1/0", cap_addr.size(), Busy); end
    // Fresh load after reset, with a Start pulse injected mid-stream.
    random_words(4);
    n = img_words.size();
    run_image(3, 9);
    vectors++; if (cap_addr.size() != n) begin miscompares++; $display("FAIL reload_nwrites: got %0d want %0d", cap_addr.size(), n); end
    for (int k = 0; k < cap_addr.size() && k < n; k++) begin
      vectors++; if (cap_addr[k] !== BASE + 32'(4*k) || cap_data[k] !== img_words[k]) begin miscompares++; $display("FAIL reload_write[%0d]: got %h/%h want %h/%h", k, cap_addr[k], cap_data[k], BASE + 32'(4*k), img_words[k]); end
    end
    vectors++; if (Done !== 1'b1 || CpuHold !== 1'b0 || WordsWritten !== 16'(n)) begin miscompares++; $display("FAIL reload_final: done=%b hold=%b words=%0d want 1/0/%0d", Done, CpuHold, WordsWritten, n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_length_bounds();
    test_timeout_partial();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the read-only Instruction_Memory port: receives a program image as a byte stream and writes it, one 32-bit word at a time, through the memory's write port.
- Holds the CPU via CpuHold from reset until a complete image has loaded; then releases the core to fetch from BASE_ADDR.
- Sits between the host byte link (UART receiver or test harness) and the instruction memory.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written
DEPTH_WORDS, 256, maximum image length in words; must be ≤ 65535 so WordsWritten cannot overflow
TIMEOUT_CYCLES, 1_000_000, idle cycles allowed between accepted bytes while loading; 0 disables the timeout

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
Start  input  1  single-cycle pulse that arms a load
ByteValid  input  1  ByteData is valid
ByteData  input  8  stream byte
ByteReady  output  1  loader accepts a byte this cycle
WriteEnable  output  1  one-cycle write strobe to instruction memory
WriteAddress  output  32  byte address of the word being written
WriteData  output  32  word being written
Busy  output  1  load in progress
Done  output  1  image loaded successfully (level)
Error  output  1  load aborted (level)
CpuHold  output  1  keeps the CPU in reset
WordsWritten  output  16  count of words written in the current load

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state IDLE; CpuHold=1.
  - All other outputs 0, and the assembly register, byte index, word index and timeout counter are cleared.
  - Reset mid-load aborts the load immediately, with no further writes.
- Handshake: a byte is accepted on a rising edge where ByteValid && ByteReady. ByteReady is 1 only in LEN and DATA, and is combinational from state.
- Image format, little-endian throughout (first byte lands in bits 7:0):
  - 4 length bytes giving N, the word count,
  - then N words of 4 bytes each.
- States:
  - IDLE: ByteReady=0. Start -> LEN; Busy=1, CpuHold=1.
  - LEN: collects 4 bytes. On the edge after the 4th byte:
    - N==0 -> DONE
    - N>DEPTH_WORDS -> ERROR
    - otherwise -> DATA.
  - DATA: collects 4 bytes per word.
    - The 4th byte of word k is accepted at edge T. For the cycle following T: WriteEnable=1, WriteAddress=BASE_ADDR+4*k, WriteData=assembled word. WordsWritten increments to k+1 at the same edge T.
    - A new byte may be accepted in the same cycle WriteEnable is high, because the assembly register is independent of the write registers.
    - If k==N-1 -> DONE at edge T, so the final WriteEnable pulse coincides with Done=1.
  - DONE: Busy=0, Done=1, CpuHold=0. Start -> LEN, clearing Done and WordsWritten and setting CpuHold=1 and Busy=1.
  - ERROR: Busy=0, Error=1, CpuHold=1, no writes. Start -> LEN, clearing Error and WordsWritten.
- Start:
  - Ignored while in LEN or DATA.
  - Bytes presented in IDLE, DONE or ERROR are not accepted.
  - Bytes presented in the same cycle as Start are not accepted; ByteReady rises the next cycle.
- Timeout:
  - The counter clears on every accepted byte and on entry to LEN.
  - It increments on each LEN/DATA cycle without an accept.
  - When it reaches TIMEOUT_CYCLES -> ERROR. Error therefore rises on the TIMEOUT_CYCLES-th edge after the last accept, or after LEN entry if no byte has arrived.
  - A partially assembled word is discarded and never written.
- WriteAddress and WriteData hold their last values when WriteEnable=0.
- WordsWritten saturates at DEPTH_WORDS (unreachable given the length check).

Test Plan:
1. Reset -> CpuHold=1; ByteReady, WriteEnable, Busy, Done, Error=0; WordsWritten=0. Pulse Start with no bytes, TIMEOUT_CYCLES=16 -> Error=1 exactly 16 edges after LEN entry.
2. Start, then bytes 02 00 00 00, 13 00 50 00, B3 00 21 00 with ByteValid held high:
   - WriteEnable pulses twice: (0x00000000, 0x00500013) and (0x00000004, 0x002100B3).
   - Done=1 in the cycle of the 2nd pulse; CpuHold=0; WordsWritten=2.
3. Same image with random ByteValid gaps (each shorter than the timeout) -> identical writes and final state; no byte lost or duplicated.
4. Length 00 00 00 00 -> DONE on the edge after the 4th byte, no WriteEnable. Length 01 01 00 00 (257, DEPTH_WORDS=256) -> Error=1, no WriteEnable, CpuHold=1.
5. TIMEOUT_CYCLES=16, length 2, then stall after the 6th data byte -> Error rises on the 16th edge after the last accept. Only word 0 was written; WordsWritten=1.
6. Drive rst_n low after the first write of a 3-word load -> outputs return to reset values asynchronously. After release, Start plus a full image loads correctly; Start pulsed mid-load is ignored.
